// File: rtl/patch_cfg_pkg.sv
// Shared types and constants for the patch configuration loader.
package patch_cfg_pkg;

    // Loader control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SMU  = 2'd1,
        SRU  = 2'd2,
        FIN  = 2'd3
    } state_t;

    // Bit positions inside cfgSel
    localparam int SEL_SMU = 0;
    localparam int SEL_SRU = 1;

    // Larger of two section lengths, used to size the section counter
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/patch_cfg_loader_if.sv
// Host word handshake between the configuration host and the loader.
interface patch_cfg_loader_if #(
    parameter int WORD_W = 8
);
    logic [WORD_W-1:0] inWord;
    logic              inWordValid;
    logic              inWordReady;

    // Host side drives the word, loader side answers with ready
    modport master (output inWord, output inWordValid, input  inWordReady);
    modport slave  (input  inWord, input  inWordValid, output inWordReady);
endinterface

// File: rtl/cfg_word_serializer.sv
// Word serializer: holds the current host word, counts its remaining bits,
// presents the MSB and decides when the next word may be taken.
module cfg_word_serializer #(
    parameter int WORD_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_shift_en,   // loader is in a shifting section
    input  logic              i_abort,      // drop everything this cycle
    input  logic              i_sec_last,   // a bit emitted now ends the section
    input  logic [WORD_W-1:0] i_word,
    input  logic              i_word_valid,
    output logic              o_ready,
    output logic              o_emit,       // one bit leaves this cycle
    output logic              o_msb
);
    localparam int BL_W = $clog2(WORD_W + 1);

    logic [WORD_W-1:0] r_shift;
    logic [BL_W-1:0]   r_bits_left;

    logic w_has_bits;
    logic w_last_bit;
    logic w_ready;
    logic w_emit;
    logic w_fire;
    logic w_flush;

    assign w_has_bits = (r_bits_left != {BL_W{1'b0}});
    assign w_last_bit = (r_bits_left == BL_W'(1));
    assign w_emit     = i_shift_en && w_has_bits;
    assign w_fire     = w_ready && i_word_valid;
    // A section end discards any unused low bits so the next section starts on a fresh word
    assign w_flush    = i_abort || (w_emit && i_sec_last);

    // Ready when empty, or when the last bit leaves now and the section continues
    always_comb begin
        w_ready = 1'b0;
        if (i_shift_en && !i_abort) begin
            if (!w_has_bits) begin
                w_ready = 1'b1;
            end else if (w_last_bit && !i_sec_last) begin
                w_ready = 1'b1;
            end else begin
                w_ready = 1'b0;
            end
        end else begin
            w_ready = 1'b0;
        end
    end

    // Shift register and remaining-bit counter
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_shift     <= {WORD_W{1'b0}};
            r_bits_left <= {BL_W{1'b0}};
        end else if (w_flush) begin
            r_shift     <= {WORD_W{1'b0}};
            r_bits_left <= {BL_W{1'b0}};
        end else if (w_fire) begin
            r_shift     <= i_word;
            r_bits_left <= BL_W'(WORD_W);
        end else if (w_emit) begin
            r_shift     <= {r_shift[WORD_W-2:0], 1'b0};
            r_bits_left <= r_bits_left - BL_W'(1);
        end else begin
            r_shift     <= r_shift;
            r_bits_left <= r_bits_left;
        end
    end

    assign o_ready = w_ready;
    assign o_emit  = w_emit;
    assign o_msb   = r_shift[WORD_W-1];

endmodule

// File: rtl/patch_cfg_loader.sv
// Patch configuration loader: serializes host words MSB-first onto the shared
// serial config line, framing an SMU section then an SRU section with exact
// bit counts and registered stream-valid strobes.
module patch_cfg_loader
    import patch_cfg_pkg::*;
#(
    parameter int WORD_W   = 8,
    parameter int SMU_BITS = 12,
    parameter int SRU_BITS = 8
) (
    input  logic               cfgClk,
    input  logic               rst,
    input  logic               cfgStart,
    input  logic [1:0]         cfgSel,
    input  logic               cfgAbort,
    patch_cfg_loader_if.slave  host,
    output logic               bitstreamSerialIn,
    output logic               smuStreamValid,
    output logic               sruStreamValid,
    output logic               busy,
    output logic               done
);
    localparam int CNT_W = $clog2(max_int(SMU_BITS, SRU_BITS) + 1);

    state_t           r_state;
    state_t           w_next_state;
    logic             r_sel_sru;
    logic [CNT_W-1:0] r_sec_cnt;

    logic w_shift_en;
    logic w_sec_last;
    logic w_sec_done;
    logic w_emit;
    logic w_msb;
    logic w_ready;

    logic w_serial_nxt;
    logic w_smu_nxt;
    logic w_sru_nxt;
    logic w_busy_nxt;
    logic w_done_nxt;

    logic r_serial;
    logic r_smu_valid;
    logic r_sru_valid;
    logic r_busy;
    logic r_done;

    assign w_shift_en = (r_state == SMU) || (r_state == SRU);
    assign w_sec_done = w_emit && w_sec_last;

    cfg_word_serializer #(
        .WORD_W (WORD_W)
    ) u_ser (
        .i_clk        (cfgClk),
        .i_rst        (rst),
        .i_shift_en   (w_shift_en),
        .i_abort      (cfgAbort),
        .i_sec_last   (w_sec_last),
        .i_word       (host.inWord),
        .i_word_valid (host.inWordValid),
        .o_ready      (w_ready),
        .o_emit       (w_emit),
        .o_msb        (w_msb)
    );

    assign host.inWordReady = w_ready;

    // Flags the bit that completes the active section
    always_comb begin
        w_sec_last = 1'b0;
        case (r_state)
            SMU:     w_sec_last = (r_sec_cnt == CNT_W'(SMU_BITS - 1));
            SRU:     w_sec_last = (r_sec_cnt == CNT_W'(SRU_BITS - 1));
            default: w_sec_last = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge cfgClk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; abort overrides every other event
    always_comb begin
        w_next_state = r_state;
        if (cfgAbort) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!cfgStart) begin
                        w_next_state = IDLE;
                    end else if (cfgSel == 2'b00) begin
                        w_next_state = FIN;
                    end else if (cfgSel[SEL_SMU]) begin
                        w_next_state = SMU;
                    end else begin
                        w_next_state = SRU;
                    end
                end
                SMU: begin
                    if (!w_sec_done) begin
                        w_next_state = SMU;
                    end else if (r_sel_sru) begin
                        w_next_state = SRU;
                    end else begin
                        w_next_state = FIN;
                    end
                end
                SRU: begin
                    if (w_sec_done) begin
                        w_next_state = FIN;
                    end else begin
                        w_next_state = SRU;
                    end
                end
                FIN:     w_next_state = IDLE;
                default: w_next_state = IDLE;
            endcase
        end
    end

    // Remember whether an SRU section follows the SMU section of this load
    always_ff @(posedge cfgClk) begin
        if (rst) begin
            r_sel_sru <= 1'b0;
        end else if ((r_state == IDLE) && cfgStart && !cfgAbort) begin
            r_sel_sru <= cfgSel[SEL_SRU];
        end else begin
            r_sel_sru <= r_sel_sru;
        end
    end

    // Section bit counter, restarted on every section entry and on abort
    always_ff @(posedge cfgClk) begin
        if (rst) begin
            r_sec_cnt <= {CNT_W{1'b0}};
        end else if (cfgAbort || w_sec_done || !w_shift_en) begin
            r_sec_cnt <= {CNT_W{1'b0}};
        end else if (w_emit) begin
            r_sec_cnt <= r_sec_cnt + CNT_W'(1);
        end else begin
            r_sec_cnt <= r_sec_cnt;
        end
    end

    // Output decode; during a stall the serial line keeps its last value
    always_comb begin
        w_serial_nxt = r_serial;
        w_smu_nxt    = 1'b0;
        w_sru_nxt    = 1'b0;
        w_busy_nxt   = (w_next_state != IDLE);
        w_done_nxt   = 1'b0;
        if (cfgAbort) begin
            w_busy_nxt = 1'b0;
            w_done_nxt = 1'b0;
        end else if (w_emit) begin
            w_serial_nxt = w_msb;
            w_smu_nxt    = (r_state == SMU);
            w_sru_nxt    = (r_state == SRU);
        end else begin
            w_done_nxt = (r_state == FIN);
        end
    end

    // Output registers
    always_ff @(posedge cfgClk) begin
        if (rst) begin
            r_serial    <= 1'b0;
            r_smu_valid <= 1'b0;
            r_sru_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_serial    <= w_serial_nxt;
            r_smu_valid <= w_smu_nxt;
            r_sru_valid <= w_sru_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign bitstreamSerialIn = r_serial;
    assign smuStreamValid    = r_smu_valid;
    assign sruStreamValid    = r_sru_valid;
    assign busy              = r_busy;
    assign done              = r_done;

endmodule
